// File: rtl/avg_ctl_param_if.sv
// FIFO-side and RAM-side signal bundle for the averaging controller.
// The controller is the master: it consumes the FIFO head and drives the RAM.
interface avg_ctl_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              clear;
  logic              empty;
  logic [DATA_W-1:0] fifo_data;
  logic              rd_ptr;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              avg_valid;
  logic              done;

  modport master (
    input  clear, empty, fifo_data,
    output rd_ptr, ram_wr, ram_addr, ram_data, avg_valid, done
  );

  modport slave (
    output clear, empty, fifo_data,
    input  rd_ptr, ram_wr, ram_addr, ram_data, avg_valid, done
  );
endinterface

// File: rtl/avg_ctl_param.sv
// FIFO-to-RAM averaging controller: pops N_AVG samples from a first-word-
// fall-through FIFO, writes their truncated mean to an auto-incrementing RAM
// address, and either wraps or stops when the RAM is full.
module avg_ctl_param #(
  parameter int DATA_W = 8,
  parameter int N_AVG  = 4,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 1
) (
  input logic             clk,
  input logic             reset,
  avg_ctl_param_if.master bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(N_AVG);
  localparam int SUM_W  = DATA_W + CNT_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(N_AVG - 1);

  typedef enum logic [1:0] {ACCUM, WRITE, FULL} state_t;

  state_t            state;
  state_t            state_next;
  logic              pop;
  logic              wr;
  logic              last_pop;
  logic              at_last;
  logic              stop_full;
  logic [SUM_W-1:0]  sum_p0;
  logic [CNT_W-1:0]  cnt;
  logic [SUM_W-1:0]  result_p1;
  logic [DATA_W-1:0] avg_p2;
  logic [ADDR_W-1:0] addr;
  logic              done_q;

  // Mean of N_AVG samples: N_AVG is a power of two, so drop the low bits
  // (truncation toward zero, no rounding).
  function automatic logic [DATA_W-1:0] trunc_mean(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:CNT_W];
  endfunction

  assign last_pop  = pop && (cnt == LAST_CNT);
  assign at_last   = (addr == LAST_ADDR);
  assign stop_full = (WRAP == 0) && at_last;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ACCUM;
    else       state <= state_next;
  end

  // Next state and strobes; clear overrides every state and strobe
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    wr         = 1'b0;
    if (bus.clear) begin
      state_next = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          pop = ~bus.empty;
          if (pop && (cnt == LAST_CNT)) state_next = WRITE;
        end
        WRITE: begin
          wr         = 1'b1;
          state_next = stop_full ? FULL : ACCUM;
        end
        FULL:    state_next = FULL;
        default: state_next = ACCUM;
      endcase
    end
  end

  // Accumulator, sample count, write address, done flag and last written mean
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_p0 <= '0;
      cnt    <= '0;
      addr   <= '0;
      done_q <= 1'b0;
      avg_p2 <= '0;
    end else if (bus.clear) begin
      sum_p0 <= '0;
      cnt    <= '0;
      addr   <= '0;
      done_q <= 1'b0;
    end else begin
      if (pop) begin
        if (cnt == LAST_CNT) begin
          sum_p0 <= '0;
          cnt    <= '0;
        end else begin
          sum_p0 <= sum_p0 + SUM_W'(bus.fifo_data);
          cnt    <= cnt + CNT_W'(1);
        end
      end
      if (wr) begin
        avg_p2 <= trunc_mean(result_p1);
        if (stop_full) done_q <= 1'b1;
        else           addr   <= at_last ? '0 : addr + ADDR_W'(1);
      end
    end
  end

  // Completed sum captured with the final pop of each group
  always_ff @(posedge clk) begin
    if (last_pop) result_p1 <= sum_p0 + SUM_W'(bus.fifo_data);
  end

  assign bus.rd_ptr    = pop & ~reset;
  assign bus.ram_wr    = wr;
  assign bus.avg_valid = wr;
  assign bus.ram_addr  = addr;
  assign bus.ram_data  = (state == WRITE) ? trunc_mean(result_p1) : avg_p2;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_avg_ctl_param.sv
// Bench for avg_ctl_param: three instances (DEPTH=4 wrap, DEPTH=4 stop-when-
// full, DATA_W=12/N_AVG=8) fed from queue-like FIFO models and compared every
// cycle against a sample-group averaging model, plus directed spot values.
module tb_avg_ctl_param;

  localparam int ND = 3;
  localparam int NAVG [ND] = '{4, 4, 8};
  localparam int DEP  [ND] = '{4, 4, 16};
  localparam int WRP  [ND] = '{1, 0, 1};
  localparam int DMAX [ND] = '{255, 255, 4095};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  avg_ctl_param_if #(.DATA_W(8),  .ADDR_W(2)) if0 ();
  avg_ctl_param_if #(.DATA_W(8),  .ADDR_W(2)) if1 ();
  avg_ctl_param_if #(.DATA_W(12), .ADDR_W(4)) if2 ();

  avg_ctl_param #(.DATA_W(8),  .N_AVG(4), .DEPTH(4),  .WRAP(1)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
  avg_ctl_param #(.DATA_W(8),  .N_AVG(4), .DEPTH(4),  .WRAP(0)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));
  avg_ctl_param #(.DATA_W(12), .N_AVG(8), .DEPTH(16), .WRAP(1)) dut2 (.clk(clk), .reset(reset), .bus(if2.master));

  logic        clr  [ND];
  logic        emp  [ND];
  logic [31:0] head [ND];
  logic        o_rd [ND];
  logic        o_wr [ND];
  logic        o_av [ND];
  logic        o_dn [ND];
  logic [31:0] o_ad [ND];
  logic [31:0] o_dt [ND];

  assign if0.clear = clr[0]; assign if0.empty = emp[0]; assign if0.fifo_data = head[0][7:0];
  assign if1.clear = clr[1]; assign if1.empty = emp[1]; assign if1.fifo_data = head[1][7:0];
  assign if2.clear = clr[2]; assign if2.empty = emp[2]; assign if2.fifo_data = head[2][11:0];

  assign o_rd[0] = if0.rd_ptr; assign o_wr[0] = if0.ram_wr; assign o_av[0] = if0.avg_valid;
  assign o_dn[0] = if0.done;   assign o_ad[0] = 32'(if0.ram_addr); assign o_dt[0] = 32'(if0.ram_data);
  assign o_rd[1] = if1.rd_ptr; assign o_wr[1] = if1.ram_wr; assign o_av[1] = if1.avg_valid;
  assign o_dn[1] = if1.done;   assign o_ad[1] = 32'(if1.ram_addr); assign o_dt[1] = 32'(if1.ram_data);
  assign o_rd[2] = if2.rd_ptr; assign o_wr[2] = if2.ram_wr; assign o_av[2] = if2.avg_valid;
  assign o_dn[2] = if2.done;   assign o_ad[2] = 32'(if2.ram_addr); assign o_dt[2] = 32'(if2.ram_data);

  // FIFO models (ever-increasing pointers into a circular store)
  int fbuf [ND][256];
  int rp [ND];
  int wp [ND];
  bit do_pop [ND];

  // Reference model: a group of N samples, its mean, where it lands
  int msum [ND];
  int mcnt [ND];
  int maddr [ND];
  int mlast [ND];
  int mwval [ND];
  bit mpend [ND];
  bit mfull [ND];

  // Write log observed on the RAM port
  int wcnt [ND];
  int wl_a [ND][128];
  int wl_d [ND][128];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s[dut%0d]: observed %0d, expected %0d", tag, k, obs, exp_v);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < ND; k++) begin
      emp[k]  = (rp[k] == wp[k]);
      head[k] = emp[k] ? 32'd0 : 32'(fbuf[k][rp[k] % 256]);
    end
  endtask

  task automatic push(input int k, input int v);
    fbuf[k][wp[k] % 256] = v;
    wp[k]++;
    refresh();
  endtask

  task automatic model_reset(input int k);
    msum[k] = 0; mcnt[k] = 0; maddr[k] = 0; mlast[k] = 0;
    mwval[k] = 0; mpend[k] = 1'b0; mfull[k] = 1'b0;
  endtask

  // Compare every output of every instance, then advance the model one cycle
  task automatic monitor();
    bit ep;
    bit ew;
    for (int k = 0; k < ND; k++) begin
      do_pop[k] = 1'b0;
      if (reset) begin
        chk("rst_rd_ptr", k, o_rd[k], 0);
        chk("rst_ram_wr", k, o_wr[k], 0);
        chk("rst_avg_valid", k, o_av[k], 0);
        chk("rst_done", k, o_dn[k], 0);
        chk("rst_ram_addr", k, o_ad[k], 0);
        chk("rst_ram_data", k, o_dt[k], 0);
        model_reset(k);
      end else begin
        ep = !mpend[k] && !mfull[k] && !emp[k] && !clr[k];
        ew = mpend[k] && !clr[k];
        chk("rd_ptr", k, o_rd[k], ep);
        chk("ram_wr", k, o_wr[k], ew);
        chk("avg_valid", k, o_av[k], ew);
        chk("ram_addr", k, o_ad[k], maddr[k]);
        chk("ram_data", k, o_dt[k], mpend[k] ? mwval[k] : mlast[k]);
        chk("done", k, o_dn[k], mfull[k]);
        if (o_wr[k] === 1'b1 && wcnt[k] < 128) begin
          wl_a[k][wcnt[k]] = int'(o_ad[k]);
          wl_d[k][wcnt[k]] = int'(o_dt[k]);
          wcnt[k]++;
        end
        do_pop[k] = (o_rd[k] === 1'b1);
        if (clr[k]) begin
          msum[k] = 0; mcnt[k] = 0; maddr[k] = 0;
          mpend[k] = 1'b0; mfull[k] = 1'b0;
        end else if (mpend[k]) begin
          mpend[k] = 1'b0;
          mlast[k] = mwval[k];
          if (WRP[k] == 0 && maddr[k] == DEP[k] - 1) mfull[k] = 1'b1;
          else maddr[k] = (maddr[k] + 1) % DEP[k];
        end else if (ep) begin
          msum[k] += int'(head[k]);
          mcnt[k]++;
          if (mcnt[k] == NAVG[k]) begin
            mwval[k] = msum[k] / NAVG[k];
            mpend[k] = 1'b1;
            msum[k] = 0;
            mcnt[k] = 0;
          end
        end
      end
    end
  endtask

  // One clock: check at the falling edge, FIFO heads advance just after the rising edge
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int k = 0; k < ND; k++)
      if (do_pop[k] && rp[k] != wp[k]) rp[k]++;
    refresh();
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < ND; k++) begin
      clr[k] = 1'b0; rp[k] = 0; wp[k] = 0; wcnt[k] = 0; do_pop[k] = 1'b0;
      model_reset(k);
    end
    refresh();

    // Reset held with non-empty FIFOs: nothing may pop
    foreach (NAVG[k]) if (k < 2) begin
      push(k, 10); push(k, 20); push(k, 30); push(k, 41);
    end
    for (int i = 0; i < 8; i++) push(2, 4095);
    repeat (3) cyc();
    reset = 1'b0;
    #1;
    chk("rd_after_reset", 0, o_rd[0], 1);

    // Second group stalls on an empty FIFO after two 255s
    push(0, 255); push(0, 255); push(1, 255); push(1, 255);
    repeat (10) cyc();
    for (int k = 0; k < 2; k++) begin
      push(k, 255); push(k, 255);
    end
    for (int i = 0; i < 12; i++) begin
      int v;
      v = int'($urandom_range(0, 255));
      push(0, v); push(1, v);
    end
    for (int i = 0; i < 8; i++) push(2, i);
    for (int i = 0; i < 8; i++) push(2, int'($urandom_range(0, 4095)));
    repeat (40) cyc();

    chk("wrap_write_count", 0, wcnt[0], 5);
    chk("basic_mean", 0, wl_d[0][0], 25);
    chk("stall_mean", 0, wl_d[0][1], 255);
    chk("wrap_addr0", 0, wl_a[0][0], 0);
    chk("wrap_addr1", 0, wl_a[0][1], 1);
    chk("wrap_addr2", 0, wl_a[0][2], 2);
    chk("wrap_addr3", 0, wl_a[0][3], 3);
    chk("wrap_addr4", 0, wl_a[0][4], 0);
    chk("full_write_count", 1, wcnt[1], 4);
    chk("full_done", 1, o_dn[1], 1);
    chk("full_no_pop", 1, o_rd[1], 0);
    chk("full_fifo_left", 1, wp[1] - rp[1], 4);
    chk("n8_max_mean", 2, wl_d[2][0], 4095);
    chk("n8_ramp_mean", 2, wl_d[2][1], 3);

    // Clear releases the full instance and restarts at address 0
    clr[1] = 1'b1;
    cyc();
    clr[1] = 1'b0;
    repeat (10) cyc();
    chk("resume_write_count", 1, wcnt[1], 5);
    chk("resume_addr", 1, wl_a[1][4], 0);
    chk("resume_done", 1, o_dn[1], 0);

    // Clear landing on the WRITE cycle cancels that write
    for (int i = 0; i < 4; i++) push(0, 200);
    repeat (4) cyc();
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    repeat (3) cyc();
    chk("clr_write_count", 0, wcnt[0], 5);
    chk("clr_write_addr", 0, o_ad[0], 0);

    // Clear after two pops discards them; next mean uses four fresh samples
    push(0, 250); push(0, 250);
    repeat (4) cyc();
    push(0, 100); push(0, 50); push(0, 7); push(0, 3);
    clr[0] = 1'b1;
    cyc();
    clr[0] = 1'b0;
    repeat (8) cyc();
    chk("fresh_write_count", 0, wcnt[0], 6);
    chk("fresh_mean", 0, wl_d[0][5], 40);
    chk("fresh_addr", 0, wl_a[0][5], 0);

    // Random traffic with gaps and occasional clears, checked by the model
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < ND; k++) begin
        if ($urandom_range(0, 1) == 1) push(k, int'($urandom_range(0, DMAX[k])));
        clr[k] = ($urandom_range(0, 49) == 0);
      end
      cyc();
    end
    for (int k = 0; k < ND; k++) clr[k] = 1'b0;
    repeat (20) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/avg_ctl_param.md
# avg_ctl_param

Parametrised FIFO-to-RAM averaging controller. Pops `N_AVG` samples from a first-word-fall-through FIFO, accumulates them, and writes their truncated mean into a sample RAM at an auto-incrementing address. Sits between the input FIFO and the averages RAM. It adds back-to-back popping, a datapath, address generation, and wrap or stop-when-full modes.

## Interface
- `DATA_W`, default 8: sample and average width.
- `N_AVG`, default 4: samples per average; must be a power of two, at least 2.
- `DEPTH`, default 16: RAM words; `ADDR_W = $clog2(DEPTH)`, minimum 1.
- `WRAP`, default 1: 1 = address wraps to 0 after `DEPTH-1`; 0 = stop when RAM is full.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `clear` in 1: synchronous restart; zeroes accumulator, count, address and `done`.
- `empty` in 1: FIFO empty flag.
- `fifo_data` in `DATA_W`: FIFO head word; valid whenever `empty`=0.
- `rd_ptr` out 1: FIFO pop strobe; one sample consumed per high cycle.
- `ram_wr` out 1: RAM write strobe, one-cycle pulse.
- `ram_addr` out `ADDR_W`: RAM write address.
- `ram_data` out `DATA_W`: average being written; valid when `ram_wr`=1.
- `avg_valid` out 1: equal to `ram_wr` (status/interrupt use).
- `done` out 1: RAM full (`WRAP`=0 only); held until `clear` or `reset`.

## Operation
- Internal widths:
  - `SUM_W = DATA_W + log2(N_AVG)`; the accumulator cannot overflow.
  - `CNT_W = log2(N_AVG)`; `cnt` runs 0..`N_AVG-1`.
- FSM states are ACCUM, WRITE and FULL. Reset state is ACCUM.
- ACCUM:
  - `rd_ptr = ~empty & ~clear`.
  - On each pop: `sum <= sum + fifo_data`, `cnt <= cnt + 1`.
  - A pop with `cnt == N_AVG-1` loads `sum + fifo_data` into the result register, zeroes `sum` and `cnt`, and moves to WRITE.
- WRITE, one cycle:
  - `ram_wr = avg_valid = 1`, `rd_ptr = 0`.
  - `ram_data = result >> log2(N_AVG)`; the mean is truncated, not rounded.
  - `ram_addr` = current address.
  - Next state:
    - If `WRAP`=0 and the address is `DEPTH-1`: go to FULL and set `done`.
    - Otherwise: go to ACCUM; address increments, wrapping `DEPTH-1` to 0.
- FULL:
  - `rd_ptr = 0`, `ram_wr = 0`, `done = 1`.
  - Stays in FULL until `clear`.
- `clear` has priority over everything. The next state is ACCUM with `sum`, `cnt`, address and `done` = 0.
  - `clear` in WRITE suppresses that cycle's `ram_wr`.
  - `clear` in ACCUM suppresses that cycle's pop.
- An `empty` rising mid-average pauses accumulation. Partial `sum`/`cnt` are retained indefinitely.
- `ram_addr` is driven from the address register in all states.
- `ram_data` holds its last written value outside WRITE.

## Timing
- Reset values while `reset`=1 and after release:
  - `rd_ptr`=0, `ram_wr`=0, `avg_valid`=0, `done`=0, `ram_addr`=0, `ram_data`=0.
  - Internal `sum`=0, `cnt`=0.
  - `rd_ptr` is forced 0 while `reset` is high.
- Pop-to-write latency: the `N_AVG`th pop is at cycle t; `ram_wr` is at t+1.
- Throughput: `N_AVG` pops per `N_AVG+1` cycles with a continuously non-empty FIFO; exactly one bubble (the WRITE cycle).
- FIFO handshake:
  - `fifo_data` is sampled on the same edge that `rd_ptr`=1.
  - The FIFO advances its head on that edge.
- `done` rises on the cycle after the last WRITE (`WRAP`=0).
- `reset` asserted mid-average or mid-WRITE discards the partial sum. No write completes after `reset` assertion.

## Test plan
- Reset behaviour: hold `reset` with `empty`=0 → all outputs 0, no pops. Release → `rd_ptr` high on the first cycle.
- Basic average (defaults): stream 10, 20, 30, 41 with `empty`=0 → `rd_ptr` high 4 cycles, then `ram_wr`=1 with `ram_data`=25 (101>>2), `ram_addr`=0. The next average goes to addr 1.
- Stalled FIFO: samples 255 ×4 with `empty`=1 for 3 cycles between samples 2 and 3 → no pop while empty. `ram_data`=255 with no overflow. `ram_wr` exactly 1 cycle after the 4th pop.
- Wrap vs full, `DEPTH`=4, 20 samples:
  - `WRAP`=1 → 5 writes to addresses 0, 1, 2, 3, 0.
  - `WRAP`=0 → 4 writes, then `done`=1 and `rd_ptr`=0 with the FIFO non-empty. `clear` resumes at addr 0.
- `clear` collisions:
  - `clear` in the WRITE cycle → no `ram_wr`, address stays 0.
  - `clear` with `empty`=0 in ACCUM after 2 pops → no pop that cycle; the next average uses 4 fresh samples.
- Parameter sweep `DATA_W`=12, `N_AVG`=8: eight samples of 4095 → `ram_data`=4095. Samples 0..7 → `ram_data`=3 (28>>3).
